// File: rtl/hc595_serial_driver.sv
// Serialises one DAT_WIDTH-bit frame into a 74HC595 chain: DAT_WIDTH sclk pulses then one rclk latch.
// Optional build macro HC595_LSB_FIRST_EN sends dat[0] first; default is MSB first.
module hc595_serial_driver #(
   parameter int unsigned DAT_WIDTH = 16,
   parameter int unsigned CLK_DIV   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DAT_WIDTH-1:0] dat,
   input  logic                 vld,
   output logic                 rdy,
   output logic                 sclk,
   output logic                 rclk,
   output logic                 dio
);

   localparam int unsigned DivW = $clog2(CLK_DIV) + 1;
   localparam int unsigned BitW = $clog2(DAT_WIDTH) + 1;
   localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
   localparam logic [BitW-1:0] BitLast = BitW'(DAT_WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StShift, StLatch} state_e;

   state_e               state_q, state_d;
   logic [DAT_WIDTH-1:0] shreg_q, shreg_d;
   logic [DivW-1:0]      div_cnt_q, div_cnt_d;
   logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
   logic                 rdy_q, rdy_d, sclk_q, sclk_d, rclk_q, rclk_d, dio_q, dio_d;

   // dio is a registered copy of the outgoing stage, so shreg holds only unsent bits.
   logic                 load_bit, next_bit;
   logic [DAT_WIDTH-1:0] load_rest, next_rest;
`ifdef HC595_LSB_FIRST_EN
   assign load_bit  = dat[0];
   assign load_rest = dat >> 1;
   assign next_bit  = shreg_q[0];
   assign next_rest = shreg_q >> 1;
`else
   assign load_bit  = dat[DAT_WIDTH-1];
   assign load_rest = dat << 1;
   assign next_bit  = shreg_q[DAT_WIDTH-1];
   assign next_rest = shreg_q << 1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         shreg_q   <= '0;
         div_cnt_q <= '0;
         bit_cnt_q <= '0;
         rdy_q     <= 1'b1;
         sclk_q    <= 1'b0;
         rclk_q    <= 1'b0;
         dio_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         div_cnt_q <= div_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         rdy_q     <= rdy_d;
         sclk_q    <= sclk_d;
         rclk_q    <= rclk_d;
         dio_q     <= dio_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      div_cnt_d = div_cnt_q;
      bit_cnt_d = bit_cnt_q;
      rdy_d     = rdy_q;
      sclk_d    = sclk_q;
      rclk_d    = rclk_q;
      dio_d     = dio_q;
      case (state_q)
         StIdle: begin
            if (vld) begin
               state_d   = StShift;
               shreg_d   = load_rest;
               dio_d     = load_bit;
               rdy_d     = 1'b0;
               sclk_d    = 1'b0;
               div_cnt_d = '0;
               bit_cnt_d = '0;
            end
         end
         StShift: begin
            if (div_cnt_q == DivLast) begin
               div_cnt_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  sclk_d = 1'b0;
                  if (bit_cnt_q == BitLast) begin
                     rclk_d    = 1'b1;
                     bit_cnt_d = '0;
                     state_d   = StLatch;
                  end else begin
                     // New low phase: the only place dio is allowed to change.
                     bit_cnt_d = bit_cnt_q + BitW'(1);
                     dio_d     = next_bit;
                     shreg_d   = next_rest;
                  end
               end
            end else begin
               div_cnt_d = div_cnt_q + DivW'(1);
            end
         end
         StLatch: begin
            if (div_cnt_q == DivLast) begin
               div_cnt_d = '0;
               rclk_d    = 1'b0;
               rdy_d     = 1'b1;
               state_d   = StIdle;
            end else begin
               div_cnt_d = div_cnt_q + DivW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign rdy  = rdy_q;
   assign sclk = sclk_q;
   assign rclk = rclk_q;
   assign dio  = dio_q;

endmodule

// File: tb/tb_hc595_serial_driver.sv
// Scoreboard bench for hc595_serial_driver: accepted frames are queued, a pin-level monitor
// rebuilds each frame from dio at sclk rises and compares on every rclk pulse.
module tb_hc595_serial_driver;

   localparam int W = 16;
   localparam int D = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [W-1:0] dat = '0, dat1 = '0;
   logic vld = 1'b0, vld1 = 1'b0;
   logic rdy, sclk, rclk, dio;
   logic rdy1, sclk1, rclk1, dio1;

   hc595_serial_driver #(.DAT_WIDTH(W), .CLK_DIV(D)) u_dut (
      .clk(clk), .rst(rst), .dat(dat), .vld(vld),
      .rdy(rdy), .sclk(sclk), .rclk(rclk), .dio(dio)
   );

   hc595_serial_driver #(.DAT_WIDTH(W), .CLK_DIV(1)) u_dut_div1 (
      .clk(clk), .rst(rst), .dat(dat1), .vld(vld1),
      .rdy(rdy1), .sclk(sclk1), .rclk(rclk1), .dio(dio1)
   );

   always #4 clk = ~clk;

   int n_cmp = 0, n_fail = 0;
   int cyc = 0;
   logic [W-1:0] exp_q[$];
   int frames_acc = 0, frames_done = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // i-th bit on the wire (0 = first sent).
   function automatic logic bit_at(input logic [W-1:0] d, input int i);
`ifdef HC595_LSB_FIRST_EN
      return d[i];
`else
      return d[W-1-i];
`endif
   endfunction

   // Monitor: phase widths, dio setup, frame contents, latch width and busy time.
   initial begin
      logic ps, pr, pd, prdy;
      int lo, hi, rhi, rdylo, stab;
      bit bq[$];
      logic [W-1:0] got, want, d;
      ps = 0; pr = 0; pd = 0; prdy = 1;
      lo = 0; hi = 0; rhi = 0; rdylo = 0; stab = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            bq.delete();
            lo = 0; hi = 0; rhi = 0; rdylo = 0; stab = 0;
         end else begin
            stab = (dio === pd) ? stab + 1 : 1;
            if (sclk && !ps) begin
               chk("sclk_low_phase", lo, D);
               chk("dio_setup", 32'(stab >= D + 1), 1);
               bq.push_back(dio);
            end
            if (!sclk && ps) chk("sclk_high_phase", hi, D);
            if (rclk && !pr) begin
               chk("bits_per_frame", bq.size(), W);
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_latch: rclk pulse with no accepted frame (t=%0t)", $time);
               end else begin
                  d = exp_q.pop_front();
                  got = '0;
                  want = '0;
                  for (int i = 0; i < W; i++) begin
                     want[W-1-i] = bit_at(d, i);
                     if (i < bq.size()) got[W-1-i] = bq[i];
                  end
                  chk("frame_bits", got, want);
                  frames_done++;
               end
               bq.delete();
            end
            if (!rclk && pr) chk("rclk_width", rhi, D);
            if (rdy && !prdy) chk("busy_cycles", rdylo, (2 * W + 1) * D);
            lo    = (!sclk && !rdy) ? lo + 1 : 0;
            hi    = sclk ? hi + 1 : 0;
            rhi   = rclk ? rhi + 1 : 0;
            rdylo = !rdy ? rdylo + 1 : 0;
         end
         ps = sclk; pr = rclk; pd = dio; prdy = rdy;
      end
   end

   task automatic send(input logic [W-1:0] d, input bit hold, output int t_acc);
      int t;
      t = 0;
      t_acc = -1;
      @(negedge clk);
      vld = 1'b1;
      dat = d;
      while (!rdy && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (!rdy) begin
         n_cmp++;
         n_fail++;
         $display("FAIL accept_timeout: rdy still 0 after %0d cycles, expected 1", t);
      end else begin
         exp_q.push_back(d);
         frames_acc++;
         t_acc = cyc;
      end
      @(posedge clk);
      #1;
      if (!hold) vld = 1'b0;
   endtask

   task automatic run_div1(input logic [W-1:0] d);
      @(negedge clk);
      vld1 = 1'b1;
      dat1 = d;
      chk("div1_idle_rdy", rdy1, 1);
      @(posedge clk);
      #1;
      vld1 = 1'b0;
      for (int k = 0; k <= 2 * W + 1; k++) begin
         chk("div1_sclk", sclk1, (k < 2 * W) ? 32'(k % 2) : 0);
         chk("div1_rclk", rclk1, 32'(k == 2 * W));
         chk("div1_rdy", rdy1, 32'(k == 2 * W + 1));
         if (k < 2 * W) chk("div1_dio", dio1, bit_at(d, k / 2));
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int ta, tb, t, cnt, aborted;
      logic prev;
      aborted = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Idle after reset.
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk("idle_outputs", {28'd0, rdy, sclk, rclk, dio}, 32'b1000);
      end

      // Single frame, then back-to-back with vld held.
      send(16'hA501, 1'b0, ta);
      send(16'hFF01, 1'b1, ta);
      send(16'h0002, 1'b0, tb);
      chk("b2b_interval", tb - ta, (2 * W + 1) * D + 1);

      // vld/dat disturbance while busy must be ignored.
      send(16'hA501, 1'b0, ta);
      repeat (9) @(negedge clk);
      dat = 16'h1234;
      vld = 1'b1;
      @(negedge clk);
      vld = 1'b0;

      // Reset at the 7th sclk rise aborts the frame.
      send(16'h5A3C, 1'b0, ta);
      cnt = 0;
      t = 0;
      prev = sclk;
      while (cnt < 7 && t < 2000) begin
         @(posedge clk);
         #1;
         if (sclk && !prev) cnt++;
         prev = sclk;
         t++;
      end
      chk("reset_point_reached", cnt, 7);
      rst = 1'b1;
      #1;
      chk("abort_outputs", {28'd0, rdy, sclk, rclk, dio}, 32'b1000);
      aborted = aborted + exp_q.size();
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      send(16'h8001, 1'b0, ta);

      // Randomised frames with random hold/gap.
      for (int n = 0; n < 20; n++) begin
         send(W'($urandom), (n != 19) && $urandom_range(0, 1) == 1, ta);
         if (vld == 1'b0) repeat ($urandom_range(0, 5)) @(negedge clk);
      end
      vld = 1'b0;

      t = 0;
      while ((exp_q.size() != 0 || !rdy) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("drain_queue", exp_q.size(), 0);
      repeat (5) @(negedge clk);
      chk("frames_latched", frames_done, frames_acc - aborted);

      // CLK_DIV=1 instance: 2-cycle sclk periods.
      run_div1(16'hFFFF);
      run_div1(W'($urandom));

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
